// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared FSM encoding and geometry helpers for the conv layer controllers
package cnn_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   function automatic int ow_f(input int img_w, input int k);
      return img_w - k + 1;
   endfunction
   function automatic int oh_f(input int img_h, input int k);
      return img_h - k + 1;
   endfunction
   function automatic int taps_f(input int k);
      return k * k;
   endfunction
   // width needed to count 0..n-1, never narrower than one bit
   function automatic int cw_f(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
   localparam int OW = ow_f(28, 3);
   localparam int OH = oh_f(28, 3);
   localparam int TAPS = taps_f(3);
endpackage

// File: rtl/win_step_cnt.sv
// win_step_cnt: wrap-around counter with clock enable and synchronous clear
module win_step_cnt #(
   parameter int W = 2,
   parameter int MAX = 2
) (
   input  logic         CLK,
   input  logic         CE,
   input  logic         SCLR,
   output logic [W-1:0] Q,
   output logic         TC
);
   assign TC = Q == W'(MAX);
   always_ff @(posedge CLK)
      if (SCLR) Q <= '0;
      else if (CE) Q <= TC ? '0 : Q + 1'b1;
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: KxK stride-1 window scan address generator with tagged read pipeline
module conv_window_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K = 3,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              acc_vld,
   output logic              acc_first,
   output logic              acc_last,
   output logic [ADDR_W-1:0] out_addr
);
   localparam int OWL = ow_f(IMG_W, K);
   localparam int OHL = oh_f(IMG_H, K);
   localparam int KW = cw_f(K);
   localparam int OCW = cw_f(OWL);
   localparam int ORW = cw_f(OHL);
   localparam int DW = cw_f(RD_LAT);
   typedef struct packed {
      logic              vld;
      logic              first;
      logic              last;
      logic [ADDR_W-1:0] oa;
   } tag_t;
   state_t state, state_n;
   logic [DW-1:0] dcnt;
   logic [KW-1:0] kc, kr;
   logic [OCW-1:0] oc;
   logic [ORW-1:0] orow;
   logic kc_tc, kr_tc, oc_tc, or_tc, sclr;
   tag_t tin;
   tag_t pipe [RD_LAT];
   assign sclr = !RST;
   win_step_cnt #(.W(KW), .MAX(K-1)) u_kc (
      .CLK, .CE(rd_en), .SCLR(sclr), .Q(kc), .TC(kc_tc)
   );
   win_step_cnt #(.W(KW), .MAX(K-1)) u_kr (
      .CLK, .CE(rd_en && kc_tc), .SCLR(sclr), .Q(kr), .TC(kr_tc)
   );
   win_step_cnt #(.W(OCW), .MAX(OWL-1)) u_oc (
      .CLK, .CE(rd_en && kc_tc && kr_tc), .SCLR(sclr), .Q(oc), .TC(oc_tc)
   );
   win_step_cnt #(.W(ORW), .MAX(OHL-1)) u_or (
      .CLK, .CE(rd_en && kc_tc && kr_tc && oc_tc), .SCLR(sclr), .Q(orow), .TC(or_tc)
   );
   always_ff @(posedge CLK)
      if (!RST) begin
         state <= IDLE;
         dcnt <= '0;
      end else begin
         state <= state_n;
         dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      end
   always_comb begin
      state_n = state;
      rd_en = state == RUN && !stall;
      busy = state != IDLE;
      done = state == DONE;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (rd_en && kc_tc && kr_tc && oc_tc && or_tc) state_n = DRAIN;
         DRAIN:   if (dcnt == DW'(RD_LAT-1)) state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   assign rd_addr = ADDR_W'((32'(orow) + 32'(kr)) * IMG_W + 32'(oc) + 32'(kc));
   always_comb begin
      tin.vld = rd_en;
      tin.first = rd_en && kc == '0 && kr == '0;
      tin.last = rd_en && kc_tc && kr_tc;
      tin.oa = ADDR_W'(32'(orow) * OWL + 32'(oc));
   end
   // shifts every cycle so a stalled cycle becomes a bubble downstream
   always_ff @(posedge CLK)
      if (!RST) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= tin;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   assign acc_vld = pipe[RD_LAT-1].vld;
   assign acc_first = pipe[RD_LAT-1].first;
   assign acc_last = pipe[RD_LAT-1].last;
   assign out_addr = pipe[RD_LAT-1].oa;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: scoreboard bench for the 4x4 K=3 window scan
module tb_conv_window_ctrl;
   localparam int AW = 10;
   logic CLK = 0, RST = 0, start = 0, stall = 0;
   logic busy, done, rd_en, acc_vld, acc_first, acc_last;
   logic [AW-1:0] rd_addr, out_addr;
   int cyc = 0, n_cmp = 0, n_bad = 0, n_done = 0, n_last = 0, k_since = 0;
   int q_addr[$], q_tag[$], q_done[$];
   int base[4] = '{0, 1, 4, 5};
   int off[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .ADDR_W(AW), .RD_LAT(1)) dut (
      .CLK(CLK), .RST(RST), .start(start), .stall(stall), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .acc_vld(acc_vld), .acc_first(acc_first),
      .acc_last(acc_last), .out_addr(out_addr)
   );
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   function automatic int enc(input int f, input int l, input int w);
      return f * 2048 + l * 1024 + w;
   endfunction
   always @(negedge CLK)
      if (RST) begin
         if (rd_en) begin
            if (q_addr.size() == 0) chk("rd_pending", q_addr.size(), 1);
            else chk("rd_addr", int'(rd_addr), q_addr.pop_front());
         end
         if (acc_vld) begin
            k_since = acc_first ? 0 : k_since + 1;
            if (acc_last) begin
               n_last++;
               chk("first_to_last", k_since, 8);
            end
            if (q_tag.size() == 0) chk("tag_pending", q_tag.size(), 1);
            else chk("tag", enc(int'(acc_first), int'(acc_last), int'(out_addr)), q_tag.pop_front());
         end
         if (done) begin
            n_done++;
            if (q_done.size() == 0) chk("done_pending", q_done.size(), 1);
            else chk("done_cycle", cyc, q_done.pop_front());
         end
      end
   task automatic scan(input int st_a, input int st_b, input int rst_at, input int pulse_at,
                       input int done_rel);
      int nrd, ntag, t0, d0, l0, rel;
      bit fin;
      nrd = (rst_at < 0) ? 36 : rst_at - 1;
      ntag = (rst_at < 0) ? 36 : rst_at - 2;
      for (int i = 0; i < nrd; i++) q_addr.push_back(base[i/9] + off[i%9]);
      for (int i = 0; i < ntag; i++) q_tag.push_back(enc(int'(i%9 == 0), int'(i%9 == 8), i/9));
      @(posedge CLK); #1;
      t0 = cyc;
      start = 1;
      if (done_rel > 0) q_done.push_back(t0 + done_rel);
      d0 = n_done;
      l0 = n_last;
      @(negedge CLK);
      chk("busy_idle", int'(busy), 0);
      fin = 0;
      rel = 1;
      while (!fin && rel <= 200) begin
         @(posedge CLK); #1;
         start = rel == pulse_at;
         stall = rel >= st_a && rel <= st_b;
         if (rel == rst_at) RST = 0;
         if (rel == rst_at + 1) RST = 1;
         @(negedge CLK);
         if (rel == 1) chk("busy_run", int'(busy), 1);
         if (rel >= st_a && rel <= st_b) begin
            chk("stall_addr", int'(rd_addr), 2);
            chk("stall_rden", int'(rd_en), 0);
         end
         if (rel >= st_a + 1 && rel <= st_b + 1) chk("stall_bubble", int'(acc_vld), 0);
         if (rel == rst_at + 1) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_rden", int'(rd_en), 0);
            chk("rst_vld", int'(acc_vld), 0);
            chk("rst_addr", int'(rd_addr), 0);
         end
         fin = (n_done != d0) || (rst_at > 0 && rel >= rst_at + 30);
         rel++;
      end
      start = 0;
      stall = 0;
      chk("done_count", n_done - d0, (done_rel > 0) ? 1 : 0);
      chk("last_count", n_last - l0, (rst_at > 0) ? 2 : 4);
      chk("addr_left", q_addr.size(), 0);
      chk("tag_left", q_tag.size(), 0);
      chk("done_left", q_done.size(), 0);
   endtask
   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_rden", int'(rd_en), 0);
      chk("reset_addr", int'(rd_addr), 0);
      chk("reset_vld", int'(acc_vld), 0);
      chk("reset_first", int'(acc_first), 0);
      chk("reset_last", int'(acc_last), 0);
      chk("reset_oaddr", int'(out_addr), 0);
      @(posedge CLK); #1;
      RST = 1;
      scan(-5, -6, -1, 10, 38);
      scan(-5, -6, -1, -1, 38);
      scan(3, 5, -1, -1, 41);
      scan(-5, -6, 20, -1, -1);
      scan(-5, -6, -1, -1, 38);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
